// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and FSM state type for the i-cache fill path
package icache_pkg;
   localparam int LINE_BITS     = 256;
   localparam int BEAT_BITS     = 32;
   localparam int BEATS         = LINE_BITS / BEAT_BITS;
   localparam int CNT_W         = 3;
   localparam int LINE_OFS_BITS = 5;
   localparam int ADDR_W        = 15;
   typedef enum logic [2:0] {IDLE, REQ, RECV, ACK, DRAIN} state_t;
endpackage

// File: rtl/fill_line_buf.sv
// fill_line_buf: beat counter and 256-bit line assembly register
module fill_line_buf
   import icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_wr_en,
   input  logic                 i_rvalid,
   input  logic [BEAT_BITS-1:0] i_rdata,
   output logic [LINE_BITS-1:0] o_line,
   output logic                 o_last_beat
);
   logic [CNT_W-1:0]     r_cnt;
   logic [LINE_BITS-1:0] r_line;
   logic [BEATS-1:0]     w_we;
   always_comb begin
      w_we = '0;
      for (int k = 0; k < BEATS; k++) w_we[k] = i_wr_en && i_rvalid && r_cnt == CNT_W'(k);
   end
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_rvalid) r_cnt <= r_cnt + 1'b1;
      if (rst) r_line <= '0;
      else for (int k = 0; k < BEATS; k++) if (w_we[k]) r_line[k*BEAT_BITS +: BEAT_BITS] <= i_rdata;
   end
   assign o_line      = r_line;
   assign o_last_beat = i_rvalid && r_cnt == CNT_W'(BEATS - 1);
endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: line-miss sequencer issuing one bus read and assembling eight beats
module icache_fill_ctrl
   import icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_ic_miss,
   input  logic [ADDR_W-1:0]    i_ic_miss_addr,
   input  logic                 i_flush,
   output logic                 o_mem_req,
   output logic [ADDR_W-1:0]    o_mem_addr,
   input  logic                 i_mem_gnt,
   input  logic                 i_mem_rvalid,
   input  logic [BEAT_BITS-1:0] i_mem_rdata,
   output logic [LINE_BITS-1:0] o_ic_fill_data,
   output logic                 o_ic_miss_ack,
   output logic                 o_busy
);
   state_t            r_state;
   logic              r_mem_req, r_ack, r_busy, r_abort;
   logic [ADDR_W-1:0] r_addr;
   logic              w_accept, w_rx, w_last;
   assign w_accept = r_state == IDLE && i_ic_miss && !i_flush;
   assign w_rx     = i_mem_rvalid && (r_state == RECV || r_state == DRAIN);
   fill_line_buf u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_accept),
      .i_wr_en     (r_state == RECV),
      .i_rvalid    (w_rx),
      .i_rdata     (i_mem_rdata),
      .o_line      (o_ic_fill_data),
      .o_last_beat (w_last)
   );
   // A completed line wins over a same-cycle flush so the bus never sees a stray extra drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mem_req <= 1'b0;
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
         r_abort   <= 1'b0;
         r_addr    <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_addr    <= {i_ic_miss_addr[ADDR_W-1:LINE_OFS_BITS], LINE_OFS_BITS'(0)};
               r_state   <= REQ;
               r_mem_req <= 1'b1;
               r_busy    <= 1'b1;
            end
            REQ: begin
               if (i_flush) r_abort <= 1'b1;
               if (i_mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= (r_abort || i_flush) ? DRAIN : RECV;
               end
            end
            RECV: if (w_last) begin
               r_state <= ACK;
               r_ack   <= 1'b1;
            end else if (i_flush) r_state <= DRAIN;
            ACK: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            DRAIN: if (w_last) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_abort <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end
   assign o_mem_req     = r_mem_req;
   assign o_mem_addr    = r_addr;
   assign o_ic_miss_ack = r_ack;
   assign o_busy        = r_busy;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed cycle-by-cycle vectors for the i-cache fill sequencer
module tb_icache_fill_ctrl;
   logic         clk = 1'b0;
   logic         rst, ic_miss, flush, mem_gnt, mem_rvalid;
   logic [14:0]  ic_miss_addr;
   logic [31:0]  mem_rdata;
   logic         mem_req, ic_miss_ack, busy;
   logic [14:0]  mem_addr;
   logic [255:0] ic_fill_data;
   int           checks = 0;
   int           errors = 0;

   typedef struct {
      logic         rst, miss, flush, gnt, rv;
      logic [14:0]  addr;
      logic [31:0]  data;
      logic         e_req, e_ack, e_busy;
      logic [14:0]  e_addr;
      logic         chk_line;
      logic [255:0] e_line;
   } vec_t;
   vec_t tbl[$];

   icache_fill_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .i_ic_miss      (ic_miss),
      .i_ic_miss_addr (ic_miss_addr),
      .i_flush        (flush),
      .o_mem_req      (mem_req),
      .o_mem_addr     (mem_addr),
      .i_mem_gnt      (mem_gnt),
      .i_mem_rvalid   (mem_rvalid),
      .i_mem_rdata    (mem_rdata),
      .o_ic_fill_data (ic_fill_data),
      .o_ic_miss_ack  (ic_miss_ack),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs are held for one cycle; expectations are the registered outputs after that edge.
   task automatic run(input string nm, input logic rst_v, miss, input logic [14:0] addr,
                      input logic fl, gnt, rv, input logic [31:0] data,
                      input logic e_req, e_ack, e_busy, input logic [14:0] e_addr);
      rst = rst_v; ic_miss = miss; ic_miss_addr = addr; flush = fl;
      mem_gnt = gnt; mem_rvalid = rv; mem_rdata = data;
      @(posedge clk);
      #1;
      chk({nm, ".req"}, 256'(mem_req), 256'(e_req));
      chk({nm, ".ack"}, 256'(ic_miss_ack), 256'(e_ack));
      chk({nm, ".busy"}, 256'(busy), 256'(e_busy));
      chk({nm, ".addr"}, 256'(mem_addr), 256'(e_addr));
   endtask

   task automatic add(input logic rst_v, miss, input logic [14:0] addr, input logic fl, gnt, rv,
                      input logic [31:0] data, input logic e_req, e_ack, e_busy,
                      input logic [14:0] e_addr, input logic cl, input logic [255:0] el);
      vec_t v;
      v.rst = rst_v; v.miss = miss; v.addr = addr; v.flush = fl; v.gnt = gnt; v.rv = rv;
      v.data = data; v.e_req = e_req; v.e_ack = e_ack; v.e_busy = e_busy; v.e_addr = e_addr;
      v.chk_line = cl; v.e_line = el;
      tbl.push_back(v);
   endtask

   function automatic logic [255:0] line_of(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
      return l;
   endfunction

   // Beats k = from..to with data base+k; beat 7 ends in ACK (recv) or IDLE (drain).
   task automatic beats(input string nm, input logic [31:0] base, input int from, input int to,
                        input logic [14:0] ea, input logic drain);
      for (int k = from; k <= to; k++)
         run($sformatf("%s.b%0d", nm, k), 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, base + 32'(k),
             1'b0, k == 7 && !drain, k != 7 || !drain, ea);
   endtask

   initial begin
      rst = 1'b1; ic_miss = 1'b0; ic_miss_addr = '0; flush = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // Reset, then minimum-latency miss at 0x0A60
      add(1, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 0, 15'h0, 1, 256'h0);
      add(0, 1, 15'h0A60, 0, 0, 0, 32'h0, 1, 0, 1, 15'h0A60, 0, 256'h0);
      add(0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h0A60, 0, 256'h0);
      for (int k = 1; k <= 8; k++)
         add(0, 0, 15'h0, 0, 0, 1, 32'h11111111 * 32'(k), 0, k == 8, 1, 15'h0A60, k == 8,
             256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
      add(0, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 0, 15'h0A60, 0, 256'h0);
      for (int i = 0; i < tbl.size(); i++) begin
         run($sformatf("t1[%0d]", i), tbl[i].rst, tbl[i].miss, tbl[i].addr, tbl[i].flush,
             tbl[i].gnt, tbl[i].rv, tbl[i].data, tbl[i].e_req, tbl[i].e_ack, tbl[i].e_busy,
             tbl[i].e_addr);
         if (tbl[i].chk_line) chk($sformatf("t1[%0d].line", i), ic_fill_data, tbl[i].e_line);
      end

      // Miss at 0x7FFF, grant in third REQ cycle, rvalid gaps after beats 2 and 5
      run("t2.miss", 0, 1, 15'h7FFF, 0, 0, 0, 32'h0, 1, 0, 1, 15'h7FE0);
      run("t2.req1", 0, 0, 15'h0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 1, 15'h7FE0);
      run("t2.req2", 0, 0, 15'h0, 0, 0, 0, 32'h0, 1, 0, 1, 15'h7FE0);
      run("t2.gnt", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h7FE0);
      beats("t2", 32'hA0000000, 0, 2, 15'h7FE0, 0);
      run("t2.gap1", 0, 1, 15'h0AA0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h7FE0);
      beats("t2", 32'hA0000000, 3, 5, 15'h7FE0, 0);
      run("t2.gap2", 0, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 1, 15'h7FE0);
      beats("t2", 32'hA0000000, 6, 7, 15'h7FE0, 0);
      chk("t2.line", ic_fill_data, line_of(32'hA0000000));
      run("t2.ackcyc", 0, 0, 15'h0, 1, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 15'h7FE0);
      run("t2.idle", 0, 0, 15'h0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 15'h7FE0);
      chk("t2.line_kept", ic_fill_data, line_of(32'hA0000000));

      // Flush in REQ before grant: request held, full drain, no ack
      run("t3.miss", 0, 1, 15'h1234, 0, 0, 0, 32'h0, 1, 0, 1, 15'h1220);
      run("t3.flush", 0, 0, 15'h0, 1, 0, 0, 32'h0, 1, 0, 1, 15'h1220);
      run("t3.req", 0, 0, 15'h0, 0, 0, 0, 32'h0, 1, 0, 1, 15'h1220);
      run("t3.gnt", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h1220);
      beats("t3", 32'hB0000000, 0, 7, 15'h1220, 1);
      run("t3.idle", 0, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 0, 15'h1220);

      // Flush after beat 3, then a new miss in the first IDLE cycle
      run("t4.miss", 0, 1, 15'h0040, 0, 0, 0, 32'h0, 1, 0, 1, 15'h0040);
      run("t4.gnt", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h0040);
      beats("t4", 32'hC0000000, 0, 3, 15'h0040, 0);
      run("t4.flush", 0, 0, 15'h0, 1, 0, 0, 32'h0, 0, 0, 1, 15'h0040);
      beats("t4d", 32'hC0000000, 4, 7, 15'h0040, 1);
      run("t4.miss2", 0, 1, 15'h0100, 0, 0, 0, 32'h0, 1, 0, 1, 15'h0100);
      run("t4.gnt2", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h0100);
      beats("t4b", 32'hD0000000, 0, 7, 15'h0100, 0);
      chk("t4.line", ic_fill_data, line_of(32'hD0000000));
      run("t4.idle", 0, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 0, 15'h0100);

      // Same-cycle flush and miss in IDLE
      run("t5.both", 0, 1, 15'h0300, 1, 0, 0, 32'h0, 0, 0, 0, 15'h0100);
      run("t5.idle", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 0, 15'h0100);

      // Reset in RECV after beat 5, then a normal full miss
      run("t6.miss", 0, 1, 15'h2000, 0, 0, 0, 32'h0, 1, 0, 1, 15'h2000);
      run("t6.gnt", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h2000);
      beats("t6", 32'hE0000000, 0, 5, 15'h2000, 0);
      run("t6.rst", 1, 0, 15'h0, 0, 0, 1, 32'hE0000006, 0, 0, 0, 15'h0);
      chk("t6.line_rst", ic_fill_data, 256'h0);
      run("t6.post", 0, 0, 15'h0, 0, 0, 1, 32'hE0000007, 0, 0, 0, 15'h0);
      run("t6.miss2", 0, 1, 15'h4AE0, 0, 0, 0, 32'h0, 1, 0, 1, 15'h4AE0);
      run("t6.gnt2", 0, 0, 15'h0, 0, 1, 0, 32'h0, 0, 0, 1, 15'h4AE0);
      beats("t6b", 32'hF0000000, 0, 7, 15'h4AE0, 0);
      chk("t6.line", ic_fill_data, line_of(32'hF0000000));
      run("t6.idle", 0, 0, 15'h0, 0, 0, 0, 32'h0, 0, 0, 0, 15'h4AE0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
